ia_stream_loader: RTL
=====================

IA_STREAM_LOADER -- requirements
Module: ia_stream_loader

Interface
REQ-001 The block SHALL expose parameter PIX_WIDTH, default 8, meaning bits per input activation pixel.
REQ-002 The block SHALL expose parameter PACK, default 8, meaning pixels packed per IA RAM word (lane 0 in the LSBs).
REQ-003 The block SHALL expose parameter addr_width_ia, default 11, meaning IA RAM address width.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to load one frame; honoured only in IDLE.
REQ-007 frame_words  input  addr_width_ia+1  number of IA RAM words in the frame (valid range 0..2^addr_width_ia), sampled on an accepted start.
REQ-008 s_valid  input  1  input pixel valid.
REQ-009 s_data  input  PIX_WIDTH  input pixel.
REQ-010 s_last  input  1  marks the final pixel of the frame.
REQ-011 s_ready  output  1  loader accepts a pixel; handshake = s_valid & s_ready.
REQ-012 ram_we  output  1  IA RAM write strobe.
REQ-013 ram_addr  output  addr_width_ia  IA RAM write address.
REQ-014 ram_wdata  output  PIX_WIDTH*PACK  IA RAM write data.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at frame completion, to Control_System.
REQ-017 error  output  1  sticky frame-length mismatch flag.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD and DONE; transitions: IDLE->LOAD on start with frame_words!=0; IDLE->DONE on start with frame_words==0; LOAD->DONE on the end handshake; DONE->IDLE unconditionally after one cycle.
REQ-019 s_ready SHALL be 1 exactly when state==LOAD (decoded combinationally from state, no dependency on s_valid).
REQ-020 On an accepted start, lane count, word count and error SHALL clear, and frame_words SHALL be captured.
REQ-021 Each handshake SHALL store s_data in lane lane_cnt (bits [lane_cnt*PIX_WIDTH +: PIX_WIDTH]) and increment lane_cnt modulo PACK.
REQ-022 A handshake filling lane PACK-1 SHALL cause, on the next cycle, ram_we=1, ram_addr=word_cnt and ram_wdata=the packed word, then word_cnt+1 (one-cycle write latency).
REQ-023 The end handshake SHALL be the first handshake with s_last=1 or the one filling lane PACK-1 of word frame_words-1, whichever comes first.
REQ-024 At an end handshake on a partial word, unfilled lanes SHALL be written as zero and the word SHALL be written on the next cycle like a full word.
REQ-025 error SHALL be set at the end handshake unless s_last=1 and it fills lane PACK-1 of word frame_words-1; it SHALL also be set when frame_words==0 is started.
REQ-026 done SHALL be 1 for exactly the DONE-state cycle, coincident with the final ram_we (no ram_we for frame_words==0).
REQ-027 ram_we SHALL be 0 in every cycle not specified by REQ-022/REQ-024; ram_addr/ram_wdata are don't-care while ram_we=0.
REQ-028 start while busy=1 SHALL be ignored; s_valid with s_ready=0 SHALL not be consumed.
REQ-029 error SHALL hold its value until the next accepted start or reset.
REQ-030 Gaps in s_valid SHALL not alter written data, addresses or write count.

Reset
REQ-031 reset SHALL, on the next edge and overriding all other inputs, force state IDLE, s_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, error=0, lane_cnt=0 and word_cnt=0.
REQ-032 Reset during LOAD SHALL discard the partial word, issue no further writes, and make the next start load from address 0.

Verification
REQ-033 frame_words=2, 16 pixels 0x01..0x10 with s_last on 0x10 -> writes addr0=0x0807060504030201 and addr1=0x100F0E0D0C0B0A09, done coincident with second ram_we, error=0.
REQ-034 frame_words=2, s_last on the 11th pixel (0x0B) -> addr1=0x00000000000B0A09, done pulse, error=1, s_ready=0 afterwards.
REQ-035 frame_words=1, 8 pixels and no s_last -> one write at addr0, done, error=1; the 9th pixel is not accepted.
REQ-036 Case REQ-033 with random s_valid gaps plus a start pulse mid-frame -> identical writes, start ignored.
REQ-037 Reset asserted after 5 handshakes -> no ram_we, all outputs at reset values; a new start with frame_words=1 writes addr0.
REQ-038 start with frame_words=0 -> done one cycle after start, no ram_we, error=1.

Source files
------------

// File: rtl/ia_stream_loader.sv
// Packs a pixel stream into IA RAM words, PACK pixels per word, one frame per start.
// Detects the end of the frame from s_last or the word count and flags length mismatches.
module ia_stream_loader #(
  parameter int PIX_WIDTH     = 8,
  parameter int PACK          = 8,
  parameter int addr_width_ia = 11
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [addr_width_ia:0]        frame_words,
  input  logic                          s_valid,
  input  logic [PIX_WIDTH-1:0]          s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic                          ram_we,
  output logic [addr_width_ia-1:0]      ram_addr,
  output logic [PIX_WIDTH*PACK-1:0]     ram_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam int WORD_W = PIX_WIDTH * PACK;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state, state_nxt;
  logic [LANE_W-1:0]       lane_cnt;
  logic [addr_width_ia:0]  word_cnt;
  logic [addr_width_ia:0]  frame_words_q;
  logic [WORD_W-1:0]       word_buf;
  logic [WORD_W-1:0]       word_packed;
  logic                    hs, lane_full, last_word, end_hs, start_ok;

  assign s_ready   = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign start_ok  = start && (state == IDLE);
  assign hs        = s_valid && s_ready;
  assign lane_full = (lane_cnt == LANE_W'(PACK - 1));
  assign last_word = (word_cnt == frame_words_q - (addr_width_ia + 1)'(1));
  assign end_hs    = hs && (s_last || (lane_full && last_word));

  // Lanes above the current one stay zero because word_buf is cleared after every write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    word_packed = word_buf;
    for (int i = 0; i < PACK; i++) begin
      if (lane_cnt == LANE_W'(i)) word_packed[i*PIX_WIDTH +: PIX_WIDTH] = s_data;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (frame_words == '0) ? DONE : LOAD;
      LOAD: if (end_hs) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the packing buffer is reset too, so a frame aborted mid-word leaves no stale lanes.
      lane_cnt      <= '0;
      word_cnt      <= '0;
      frame_words_q <= '0;
      word_buf      <= '0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      error         <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (start_ok) begin
        lane_cnt      <= '0;
        word_cnt      <= '0;
        word_buf      <= '0;
        frame_words_q <= frame_words;
        error         <= (frame_words == '0);
      end else if (hs) begin
        if (lane_full || end_hs) begin
          ram_we    <= 1'b1;
          ram_addr  <= word_cnt[addr_width_ia-1:0];
          ram_wdata <= word_packed;
          word_cnt  <= word_cnt + (addr_width_ia + 1)'(1);
          lane_cnt  <= '0;
          word_buf  <= '0;
        end else begin
          word_buf <= word_packed;
          lane_cnt <= lane_cnt + LANE_W'(1);
        end
        // A clean frame ends exactly on the last lane of the last word, flagged by s_last.
        if (end_hs) error <= !(s_last && lane_full && last_word);
      end
    end
  end

endmodule
